// File: rtl/oam_dma_arbiter_if.sv
// CPU-side, main-bus, high-bus and OAM write signals of the OAM DMA arbiter.
// master is the arbiter's view; slave is the surrounding system's view.
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  hi_addr;
    logic        hi_enable;
    logic        hi_write;
    logic [7:0]  hi_wdata;
    logic [7:0]  hi_rdata;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport master (
        input  cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
        output cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
               hi_addr, hi_enable, hi_write, hi_wdata,
               oam_addr, oam_write, oam_wdata, dma_active
    );

    modport slave (
        output cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
        input  cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
               hi_addr, hi_enable, hi_write, hi_wdata,
               oam_addr, oam_write, oam_wdata, dma_active
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// FF46 OAM DMA engine and CPU bus router: one byte per 4-clk M-cycle, DMA_LEN+1 M-cycles per copy, CPU never stalled.
// Main-bus CPU accesses are silently blocked during DMA; OAM_DMA_BUS_CONFLICT_EN makes blocked reads return the DMA byte.
module oam_dma_arbiter #(
    parameter int DMA_LEN = 160
) (
    input  logic               clk,
    input  logic               reset,
    oam_dma_arbiter_if.master  io
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFER} state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] t_q, t_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic       act_q, act_d;

    logic       hi_sel;
    logic       ff46_sel;
    logic       ff46_wr;
    logic       t3;
    logic       dma_on;
    logic [7:0] src_eff;
    logic [7:0] blocked_rdata;

    assign t3       = (t_q == 2'd3);
    assign hi_sel   = (io.cpu_addr[15:8] == 8'hFF);
    assign ff46_sel = (io.cpu_addr == 16'hFF46);
    assign ff46_wr  = io.cpu_enable & io.cpu_write & ff46_sel & t3;
    // Reset takes the bus back in the same clk it is asserted.
    assign dma_on   = act_q & ~reset;
    assign src_eff  = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign blocked_rdata = io.bus_rdata;
`else
    assign blocked_rdata = 8'hFF;
`endif

    always_comb begin
        t_d     = t_q + 2'd1;
        state_d = state_q;
        reg_d   = reg_q;
        src_d   = src_q;
        idx_d   = idx_q;
        act_d   = act_q;
        if (t3) begin
            // A running copy keeps advancing even through a restart's START M-cycle.
            if (act_q) begin
                if (idx_q == LAST_IDX) begin
                    act_d = 1'b0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            if (ff46_wr) begin
                reg_d   = io.cpu_wdata;
                state_d = ST_START;
            end else if (state_q == ST_START) begin
                state_d = ST_XFER;
                src_d   = reg_q;
                idx_d   = 8'd0;
                act_d   = 1'b1;
            end else if ((state_q == ST_XFER) && (idx_q == LAST_IDX)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q     <= 2'd0;
            state_q <= ST_IDLE;
            reg_q   <= 8'd0;
            src_q   <= 8'd0;
            idx_q   <= 8'd0;
            act_q   <= 1'b0;
        end else begin
            t_q     <= t_d;
            state_q <= state_d;
            reg_q   <= reg_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
        end
    end

    assign io.dma_active = act_q;
    assign io.oam_addr   = idx_q;
    assign io.oam_write  = dma_on & t3;
    assign io.oam_wdata  = dma_on ? io.bus_rdata : 8'h00;

    assign io.hi_addr   = io.cpu_addr[7:0];
    assign io.hi_wdata  = io.cpu_wdata;
    assign io.hi_enable = io.cpu_enable & hi_sel & ~ff46_sel;
    assign io.hi_write  = io.cpu_write & hi_sel & ~ff46_sel;

    always_comb begin
        io.bus_addr   = io.cpu_addr;
        io.bus_enable = io.cpu_enable & ~hi_sel;
        io.bus_write  = io.cpu_write & ~hi_sel;
        io.bus_wdata  = io.cpu_wdata;
        if (dma_on) begin
            io.bus_addr   = {src_eff, idx_q};
            io.bus_enable = 1'b1;
            io.bus_write  = 1'b0;
            io.bus_wdata  = 8'h00;
        end
    end

    always_comb begin
        io.cpu_rdata = io.bus_rdata;
        if (ff46_sel) begin
            io.cpu_rdata = reg_q;
        end else if (hi_sel) begin
            io.cpu_rdata = io.hi_rdata;
        end else if (dma_on) begin
            io.cpu_rdata = blocked_rdata;
        end
    end
endmodule
